// File: rtl/decode_stage_ctrl_pkg.sv
// decode_stage_ctrl_pkg
//   Shared definitions for the ID-stage controller:
//   - imm_type_e   : immediate-type select driven to the immediate generator
//   - OP_*         : RV32 base opcodes recognised by the decoder
//   - ctrl_state_e : stall/flush sequencer states
//   - imm_uses_rs1/imm_uses_rs2 : which source fields an instruction format reads
package decode_stage_ctrl_pkg;

    typedef enum logic [2:0] {
        IMM_R = 3'd0,
        IMM_I = 3'd1,
        IMM_S = 3'd2,
        IMM_B = 3'd3,
        IMM_U = 3'd4,
        IMM_J = 3'd5
    } imm_type_e;

    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_LDSTALL = 2'd1,
        ST_MEMWAIT = 2'd2
    } ctrl_state_e;

    // U- and J-type carry immediate bits where rs1 would sit.
    function automatic logic imm_uses_rs1(input logic [2:0] t);
        return !((t == IMM_U) || (t == IMM_J));
    endfunction

    // Only R, S and B formats have a real rs2 field.
    function automatic logic imm_uses_rs2(input logic [2:0] t);
        return (t == IMM_R) || (t == IMM_S) || (t == IMM_B);
    endfunction

endpackage

// File: rtl/decode_stage_ctrl_imm_type_decoder.sv
// decode_stage_ctrl_imm_type_decoder
//   Combinational opcode classifier.
//   Ports:
//     opcode   in  7  instruction bits [6:0]
//     legal    out 1  opcode is one of the supported RV32 base opcodes
//     imm_type out 3  immediate-type select (IMM_R for unknown opcodes)
module decode_stage_ctrl_imm_type_decoder
    import decode_stage_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    output logic       legal,
    output logic [2:0] imm_type
);

    always_comb begin
        legal    = 1'b1;
        imm_type = IMM_R;
        case (opcode)
            OP_OP:                      imm_type = IMM_R;
            OP_IMM, OP_LOAD, OP_JALR:   imm_type = IMM_I;
            OP_STORE:                   imm_type = IMM_S;
            OP_BRANCH:                  imm_type = IMM_B;
            OP_LUI, OP_AUIPC:           imm_type = IMM_U;
            OP_JAL:                     imm_type = IMM_J;
            default: begin
                legal    = 1'b0;
                imm_type = IMM_R;
            end
        endcase
    end

endmodule

// File: rtl/decode_stage_ctrl.sv
// decode_stage_ctrl
//   ID-stage controller: owns the IF/ID register, decodes the immediate type,
//   and sequences stalls/flushes for load-use hazards, taken branches resolved
//   in EX and data-memory waits. Counts stalled cycles (saturating).
//   Ports:
//     CPU_CLK, CPU_RST        clock, async active-high reset
//     InstrF, FetchValid      instruction from fetch and its valid flag
//     BranchE                 taken branch/jump resolved in EX
//     MemReadE, RdE           EX instruction is a load, and its destination
//     DMemBusy                data memory not ready, freeze the pipe
//     InstrD, ValidD          registered ID instruction, real-instruction flag
//     ImmTypeD, Rs1D, Rs2D    registered immediate type and source fields
//     StallF, StallD, FlushE  combinational pipeline controls
//     StallCount              saturating count of StallD cycles
//     state_dbg               current sequencer state
//   Handshake: the pipeline has no valid/ready pair; StallD=1 means IF/ID
//   holds this cycle, otherwise it loads (instruction or bubble) at the edge.
module decode_stage_ctrl
    import decode_stage_ctrl_pkg::*;
#(
    parameter int          CNT_W     = 16,
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic             CPU_CLK,
    input  logic             CPU_RST,
    input  logic [31:0]      InstrF,
    input  logic             FetchValid,
    input  logic             BranchE,
    input  logic             MemReadE,
    input  logic [4:0]       RdE,
    input  logic             DMemBusy,
    output logic [31:0]      InstrD,
    output logic             ValidD,
    output logic [2:0]       ImmTypeD,
    output logic [4:0]       Rs1D,
    output logic [4:0]       Rs2D,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushE,
    output logic [CNT_W-1:0] StallCount,
    output ctrl_state_e      state_dbg
);

    ctrl_state_e       state_q, state_d;
    logic [31:0]       instr_q, instr_d;
    logic              valid_q, valid_d;
    logic [2:0]        imm_q, imm_d;
    logic [4:0]        rs1_q, rs1_d;
    logic [4:0]        rs2_q, rs2_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              dec_legal;
    logic [2:0]        dec_type;
    logic              lu_hazard;
    logic              lu_enable;
    logic              if_id_flush;
    logic              stall_f, stall_d, flush_e;

    decode_stage_ctrl_imm_type_decoder u_imm_dec (
        .opcode   (InstrF[6:0]),
        .legal    (dec_legal),
        .imm_type (dec_type)
    );

    // Load in EX writes a register the ID instruction actually reads.
    always_comb begin
        lu_hazard = MemReadE && (RdE != 5'd0) && valid_q &&
                    ((imm_uses_rs1(imm_q) && (rs1_q == RdE)) ||
                     (imm_uses_rs2(imm_q) && (rs2_q == RdE)));
    end

    // Sequencer. MEMWAIT with the memory ready behaves exactly like RUN, and
    // LDSTALL is RUN without hazard detection since EX now holds the bubble.
    always_comb begin
        state_d     = ST_RUN;
        stall_f     = 1'b0;
        stall_d     = 1'b0;
        flush_e     = 1'b0;
        if_id_flush = 1'b0;
        lu_enable   = 1'b1;

        case (state_q)
            ST_LDSTALL: lu_enable = 1'b0;
            ST_RUN,
            ST_MEMWAIT: lu_enable = 1'b1;
            default:    lu_enable = 1'b1;
        endcase

        if (DMemBusy) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            state_d = ST_MEMWAIT;
        end else if (BranchE) begin
            flush_e     = 1'b1;
            if_id_flush = 1'b1;
            state_d     = ST_RUN;
        end else if (lu_hazard && lu_enable) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
            state_d = ST_LDSTALL;
        end else begin
            state_d = ST_RUN;
        end

        // Controls stay quiet while reset is held.
        if (CPU_RST) begin
            stall_f     = 1'b0;
            stall_d     = 1'b0;
            flush_e     = 1'b0;
            if_id_flush = 1'b0;
        end
    end

    // IF/ID register and stall counter.
    always_comb begin
        instr_d = instr_q;
        valid_d = valid_q;
        imm_d   = imm_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        cnt_d   = cnt_q;

        if (stall_d) begin
            if (!(&cnt_q)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (if_id_flush || !FetchValid) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
            imm_d   = IMM_I;
            rs1_d   = 5'd0;
            rs2_d   = 5'd0;
        end else begin
            instr_d = InstrF;
            valid_d = dec_legal;
            imm_d   = dec_type;
            rs1_d   = InstrF[19:15];
            rs2_d   = InstrF[24:20];
        end
    end

    always_ff @(posedge CPU_CLK or posedge CPU_RST) begin
        if (CPU_RST) begin
            state_q <= ST_RUN;
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
            imm_q   <= IMM_I;
            rs1_q   <= 5'd0;
            rs2_q   <= 5'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            imm_q   <= imm_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            cnt_q   <= cnt_d;
        end
    end

    assign InstrD     = instr_q;
    assign ValidD     = valid_q;
    assign ImmTypeD   = imm_q;
    assign Rs1D       = rs1_q;
    assign Rs2D       = rs2_q;
    assign StallF     = stall_f;
    assign StallD     = stall_d;
    assign FlushE     = flush_e;
    assign StallCount = cnt_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_decode_stage_ctrl.sv
// tb_decode_stage_ctrl
//   Bench for decode_stage_ctrl (CNT_W=4 so counter saturation is reachable).
//   The driver applies one input vector per cycle shortly after the rising
//   edge, evaluates the reference model and queues the expected outputs for
//   that cycle; the monitor samples the DUT on the falling edge and compares.
module tb_decode_stage_ctrl;
    import decode_stage_ctrl_pkg::*;

    localparam int          CNT_W = 4;
    localparam logic [31:0] NOP   = 32'h00000013;
    localparam logic [31:0] ADD_X3_X1_X2 = 32'h002081B3;
    localparam logic [31:0] ADDI_X1      = 32'h00A00093;
    localparam logic [31:0] LUI_X1_RS1F1 = 32'h000080B7;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [31:0]      instr_f = NOP;
    logic             fetch_valid = 1'b0;
    logic             branch_e = 1'b0;
    logic             mem_read_e = 1'b0;
    logic [4:0]       rd_e = 5'd0;
    logic             dmem_busy = 1'b0;
    logic [31:0]      instr_d;
    logic             valid_d;
    logic [2:0]       imm_type_d;
    logic [4:0]       rs1_d, rs2_d;
    logic             stall_f, stall_d, flush_e;
    logic [CNT_W-1:0] stall_count;
    ctrl_state_e      state_dbg;

    decode_stage_ctrl #(.CNT_W(CNT_W), .NOP_INSTR(NOP)) dut (
        .CPU_CLK    (clk),
        .CPU_RST    (rst),
        .InstrF     (instr_f),
        .FetchValid (fetch_valid),
        .BranchE    (branch_e),
        .MemReadE   (mem_read_e),
        .RdE        (rd_e),
        .DMemBusy   (dmem_busy),
        .InstrD     (instr_d),
        .ValidD     (valid_d),
        .ImmTypeD   (imm_type_d),
        .Rs1D       (rs1_d),
        .Rs2D       (rs2_d),
        .StallF     (stall_f),
        .StallD     (stall_d),
        .FlushE     (flush_e),
        .StallCount (stall_count),
        .state_dbg  (state_dbg)
    );

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic             sf;
        logic             sd;
        logic             fl;
        logic [31:0]      instr;
        logic             valid;
        logic [2:0]       imm;
        logic [4:0]       rs1;
        logic [4:0]       rs2;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    localparam int W = $bits(exp_t);
    logic [W-1:0] exp_q[$];

    int checks = 0;
    int passed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    endtask

    // ---------------- reference model ----------------
    // ID-stage contents as seen by the architecture, plus one bit recording
    // that the previous cycle was a load-use stall (two in a row never occur).
    logic [31:0]      m_instr;
    logic             m_valid;
    logic [2:0]       m_imm;
    logic [4:0]       m_rs1, m_rs2;
    logic [CNT_W-1:0] m_cnt;
    logic             m_lu_last;

    function automatic logic [3:0] ref_decode(input logic [6:0] op);
        // returns {legal, type}
        case (op)
            7'h33:              return {1'b1, 3'(IMM_R)};
            7'h13, 7'h03, 7'h67: return {1'b1, 3'(IMM_I)};
            7'h23:              return {1'b1, 3'(IMM_S)};
            7'h63:              return {1'b1, 3'(IMM_B)};
            7'h37, 7'h17:       return {1'b1, 3'(IMM_U)};
            7'h6F:              return {1'b1, 3'(IMM_J)};
            default:            return {1'b0, 3'(IMM_R)};
        endcase
    endfunction

    task automatic model_reset();
        m_instr   = NOP;
        m_valid   = 1'b0;
        m_imm     = IMM_I;
        m_rs1     = 5'd0;
        m_rs2     = 5'd0;
        m_cnt     = '0;
        m_lu_last = 1'b0;
    endtask

    // ---------------- driver ----------------
    task automatic step(input logic [31:0] ins, input logic fv, input logic br,
                        input logic mr, input logic [4:0] rd, input logic busy,
                        input logic r);
        exp_t e;
        logic lu, sf, sd, fl, r1, r2;
        logic [3:0] dec;
        @(posedge clk);
        #2;
        instr_f = ins; fetch_valid = fv; branch_e = br;
        mem_read_e = mr; rd_e = rd; dmem_busy = busy; rst = r;
        if (r) model_reset();

        r1 = !(m_imm == IMM_U || m_imm == IMM_J);
        r2 = (m_imm == IMM_R || m_imm == IMM_S || m_imm == IMM_B);
        lu = mr && (rd != 0) && m_valid && ((r1 && m_rs1 == rd) || (r2 && m_rs2 == rd));

        sf = 1'b0; sd = 1'b0; fl = 1'b0;
        if (!r) begin
            if (busy) begin
                sf = 1'b1; sd = 1'b1;
            end else if (br) begin
                fl = 1'b1;
            end else if (lu && !m_lu_last) begin
                sf = 1'b1; sd = 1'b1; fl = 1'b1;
            end
        end

        e = '{sf: sf, sd: sd, fl: fl, instr: m_instr, valid: m_valid, imm: m_imm,
              rs1: m_rs1, rs2: m_rs2, cnt: m_cnt};
        exp_q.push_back(e);

        if (!r) begin
            if (sd) begin
                if (int'(m_cnt) < (2 ** CNT_W) - 1) m_cnt = m_cnt + 1'b1;
            end else if (br || !fv) begin
                m_instr = NOP; m_valid = 1'b0; m_imm = IMM_I; m_rs1 = 0; m_rs2 = 0;
            end else begin
                dec     = ref_decode(ins[6:0]);
                m_instr = ins;
                m_valid = dec[3];
                m_imm   = dec[2:0];
                m_rs1   = ins[19:15];
                m_rs2   = ins[24:20];
            end
            m_lu_last = sf && fl;
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0] ops[10];
        logic [31:0] v;
        ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h7F};
        v = $urandom;
        v[6:0]   = ops[$urandom_range(0, 9)];
        v[19:15] = 5'($urandom_range(0, 3));
        v[24:20] = 5'($urandom_range(0, 3));
        return v;
    endfunction

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("StallF",     32'(stall_f),     32'(e.sf));
                check("StallD",     32'(stall_d),     32'(e.sd));
                check("FlushE",     32'(flush_e),     32'(e.fl));
                check("InstrD",     instr_d,          e.instr);
                check("ValidD",     32'(valid_d),     32'(e.valid));
                check("ImmTypeD",   32'(imm_type_d),  32'(e.imm));
                check("Rs1D",       32'(rs1_d),       32'(e.rs1));
                check("Rs2D",       32'(rs2_d),       32'(e.rs2));
                check("StallCount", 32'(stall_count), 32'(e.cnt));
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [31:0] dec_vec[6];

    initial begin
        model_reset();
        dec_vec = '{32'h00A00093, 32'h00112023, 32'hFE000EE3, 32'h000010B7,
                    32'h0000006F, 32'h0000007F};

        step(NOP, 0, 0, 0, 0, 0, 1);
        step(NOP, 0, 0, 0, 0, 0, 1);
        step(NOP, 0, 0, 0, 0, 0, 0);

        // decode of each format, then an illegal opcode
        foreach (dec_vec[i]) step(dec_vec[i], 1, 0, 0, 0, 0, 0);
        step(NOP, 0, 0, 0, 0, 0, 0);

        // load-use on rs1 of an add: one stall cycle, then the add advances
        step(ADD_X3_X1_X2, 1, 0, 0, 0, 0, 0);
        step(ADDI_X1,      1, 0, 1, 1, 0, 0);
        step(ADDI_X1,      1, 0, 1, 1, 0, 0);
        step(ADDI_X1,      1, 0, 0, 0, 0, 0);
        // RdE=0 never stalls
        step(ADD_X3_X1_X2, 1, 0, 0, 0, 0, 0);
        step(LUI_X1_RS1F1, 1, 0, 1, 0, 0, 0);
        // lui whose rs1 field matches RdE does not stall
        step(ADD_X3_X1_X2, 1, 0, 1, 1, 0, 0);
        step(ADDI_X1,      1, 0, 0, 0, 0, 0);

        // branch together with a load-use hazard: flush only
        step(ADD_X3_X1_X2, 1, 0, 0, 0, 0, 0);
        step(ADDI_X1,      1, 1, 1, 1, 0, 0);
        step(ADDI_X1,      1, 0, 0, 0, 0, 0);

        // reset asserted while in the load-use stall
        step(ADD_X3_X1_X2, 1, 0, 0, 0, 0, 0);
        step(ADDI_X1,      1, 0, 1, 2, 0, 0);
        step(ADDI_X1,      1, 0, 0, 0, 0, 1);
        step(ADDI_X1,      1, 0, 0, 0, 0, 0);

        // memory wait with a pending branch, flush applied once memory is ready
        for (int i = 0; i < 5; i++) step(ADD_X3_X1_X2, 1, 1, 0, 0, 1, 0);
        step(ADD_X3_X1_X2, 1, 1, 0, 0, 0, 0);
        step(ADD_X3_X1_X2, 1, 0, 0, 0, 0, 0);

        // long memory wait: counter must saturate
        for (int i = 0; i < 20; i++) step(ADDI_X1, 1, 0, 0, 0, 1, 0);
        step(ADDI_X1, 1, 0, 0, 0, 0, 1);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(rand_instr(),
                 $urandom_range(0, 99) < 85,
                 $urandom_range(0, 99) < 10,
                 $urandom_range(0, 99) < 40,
                 5'($urandom_range(0, 3)),
                 $urandom_range(0, 99) < 10,
                 $urandom_range(0, 199) == 0);
        end

        // drain, bounded
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() == 0) passed++;
        else $display("FAIL drain: %0d entries left, expected 0", exp_q.size());

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
